// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state codes, opcode/funct
// constants, control-field encodings and the bundled strobe struct.
package mips_multicycle_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JR        = 4'd12,
        S_JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_JAL) ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_ORI)   || (op == OP_LW)   || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer (master) and the datapath (slave).
// MULTI_MEM_WAIT_EN adds the memReady handshake from memory.
interface mips_multicycle_ctrl_if;
    import mips_multicycle_ctrl_pkg::*;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               aluZero;
`ifdef MULTI_MEM_WAIT_EN
    logic               memReady;
`endif
    logic               pcWrite;
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               irWrite;
    logic [1:0]         regDst;
    logic [1:0]         memToReg;
    logic               regWrite;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [2:0]         aluOp;
    logic [1:0]         pcSrc;
    logic               illegalOp;
    logic [STATE_W-1:0] state;

`ifdef MULTI_MEM_WAIT_EN
    modport master (
        input  opcode, funct, aluZero, memReady,
        output pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp, state
    );
    modport slave (
        output opcode, funct, aluZero, memReady,
        input  pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp, state
    );
`else
    modport master (
        input  opcode, funct, aluZero,
        output pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp, state
    );
    modport slave (
        output opcode, funct, aluZero,
        input  pcWrite, iorD, memRead, memWrite, irWrite, regDst, memToReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp, state
    );
`endif

endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// State -> control strobe decode for the multi-cycle sequencer (Moore, except the
// branch PC load and illegalOp). MULTI_MEM_WAIT_EN gates FETCH loads on memReady.
module mips_multicycle_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
`ifdef MULTI_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output ctrl_t      ctrl
);

    logic fetch_load;

`ifdef MULTI_MEM_WAIT_EN
    assign fetch_load = mem_ready;
`else
    assign fetch_load = 1'b1;
`endif

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = fetch_load;
                    ctrl.pc_write  = fetch_load;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_src    = PC_ALU;
                end
                S_DECODE: begin
                    // Branch target is computed speculatively into ALUOut here.
                    ctrl.alu_src_b  = SRCB_IMMSH2;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.illegal_op = !op_supported(opcode);
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_READ: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_dst    = RD_RT;
                    ctrl.mem_to_reg = M2R_MDR;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_dst    = RD_RD;
                    ctrl.mem_to_reg = M2R_ALU;
                    ctrl.reg_write  = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PC_ALUOUT;
                    ctrl.pc_write  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                end
                S_JUMP: begin
                    ctrl.pc_src   = PC_JUMP;
                    ctrl.pc_write = 1'b1;
                end
                S_IMM_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                end
                S_IMM_WB: begin
                    ctrl.reg_dst    = RD_RT;
                    ctrl.mem_to_reg = M2R_ALU;
                    ctrl.reg_write  = 1'b1;
                end
                S_JR: begin
                    ctrl.pc_src   = PC_RS;
                    ctrl.pc_write = 1'b1;
                end
                S_JAL: begin
                    // PC already advanced in FETCH, so the link value is PC+4.
                    ctrl.reg_dst    = RD_RA;
                    ctrl.mem_to_reg = M2R_PC;
                    ctrl.reg_write  = 1'b1;
                    ctrl.pc_src     = PC_JUMP;
                    ctrl.pc_write   = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: state register plus next-state logic.
// Build option MULTI_MEM_WAIT_EN stretches memory states until memReady.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_ready;

`ifdef MULTI_MEM_WAIT_EN
    assign mem_ready = bus.memReady;
`else
    assign mem_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:       state_next = (bus.funct == FUNCT_JR) ? S_JR : S_R_EXEC;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                    OP_ADDI, OP_ORI: state_next = S_IMM_EXEC;
                    OP_J:           state_next = S_JUMP;
                    OP_JAL:         state_next = S_JAL;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_next = S_R_WB;
            S_IMM_EXEC:  state_next = S_IMM_WB;
            default:     state_next = S_FETCH;
        endcase
    end

    mips_multicycle_ctrl_decode u_decode (
        .reset     (reset),
        .state     (state_reg),
        .opcode    (bus.opcode),
        .alu_zero  (bus.aluZero),
`ifdef MULTI_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .ctrl      (ctrl)
    );

    assign bus.pcWrite   = ctrl.pc_write;
    assign bus.iorD      = ctrl.iord;
    assign bus.memRead   = ctrl.mem_read;
    assign bus.memWrite  = ctrl.mem_write;
    assign bus.irWrite   = ctrl.ir_write;
    assign bus.regDst    = ctrl.reg_dst;
    assign bus.memToReg  = ctrl.mem_to_reg;
    assign bus.regWrite  = ctrl.reg_write;
    assign bus.aluSrcA   = ctrl.alu_src_a;
    assign bus.aluSrcB   = ctrl.alu_src_b;
    assign bus.aluOp     = ctrl.alu_op;
    assign bus.pcSrc     = ctrl.pc_src;
    assign bus.illegalOp = ctrl.illegal_op;
    assign bus.state     = reset ? '0 : state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level model gives the
// expected state walk and strobes per cycle; literal pins anchor latencies and key cases.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSrc;
        logic       illegalOp;
    } ov_t;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic exp_valid = 1'b0;
    ov_t  exp_vec;
    int   exp_state;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ov_t dut_out();
        ov_t o;
        o.pcWrite   = bus.pcWrite;
        o.iorD      = bus.iorD;
        o.memRead   = bus.memRead;
        o.memWrite  = bus.memWrite;
        o.irWrite   = bus.irWrite;
        o.regDst    = bus.regDst;
        o.memToReg  = bus.memToReg;
        o.regWrite  = bus.regWrite;
        o.aluSrcA   = bus.aluSrcA;
        o.aluSrcB   = bus.aluSrcB;
        o.aluOp     = bus.aluOp;
        o.pcSrc     = bus.pcSrc;
        o.illegalOp = bus.illegalOp;
        return o;
    endfunction

    // Sequence of numbered steps an instruction walks through, from the state table.
    function automatic iq_t path(input int op, input int fn);
        iq_t q;
        q = '{0, 1};
        case (op)
            0:       if (fn == 8) q.push_back(12); else begin q.push_back(6); q.push_back(7); end
            4, 5:    q.push_back(8);
            35:      begin q.push_back(2); q.push_back(3); q.push_back(4); end
            43:      begin q.push_back(2); q.push_back(5); end
            8, 13:   begin q.push_back(10); q.push_back(11); end
            2:       q.push_back(9);
            3:       q.push_back(13);
            default: ;
        endcase
        return q;
    endfunction

    // What the datapath must see during a given step of a given instruction.
    function automatic ov_t model(input int st, input int op, input logic z);
        ov_t o;
        bit  known;
        o = '0;
        known = (op == 0) || (op == 2) || (op == 3) || (op == 4) || (op == 5) ||
                (op == 8) || (op == 13) || (op == 35) || (op == 43);
        case (st)
            0:  begin o.memRead = 1; o.irWrite = 1; o.pcWrite = 1; o.aluSrcB = 2'd1; end
            1:  begin o.aluSrcB = 2'd3; o.illegalOp = !known; end
            2:  begin o.aluSrcA = 1; o.aluSrcB = 2'd2; end
            3:  begin o.iorD = 1; o.memRead = 1; end
            4:  begin o.memToReg = 2'd1; o.regWrite = 1; end
            5:  begin o.iorD = 1; o.memWrite = 1; end
            6:  begin o.aluSrcA = 1; o.aluOp = 3'd2; end
            7:  begin o.regDst = 2'd1; o.regWrite = 1; end
            8:  begin o.aluSrcA = 1; o.aluOp = 3'd1; o.pcSrc = 2'd1;
                      o.pcWrite = (op == 4) ? z : !z; end
            9:  begin o.pcSrc = 2'd2; o.pcWrite = 1; end
            10: begin o.aluSrcA = 1; o.aluSrcB = 2'd2; o.aluOp = (op == 13) ? 3'd3 : 3'd0; end
            11: o.regWrite = 1;
            12: begin o.pcSrc = 2'd3; o.pcWrite = 1; end
            13: begin o.regDst = 2'd2; o.memToReg = 2'd2; o.regWrite = 1;
                      o.pcSrc = 2'd2; o.pcWrite = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_out() !== exp_vec || bus.state !== 4'(exp_state)) begin
                failures++;
                $display("FAIL model t=%0t state got=%0d want=%0d strobes got=%h want=%h",
                         $time, bus.state, exp_state, dut_out(), exp_vec);
            end
        end
    end

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input int op, input int fn, input logic z);
        iq_t q;
        bus.opcode  = 6'(op);
        bus.funct   = 6'(fn);
        bus.aluZero = z;
        q = path(op, fn);
        foreach (q[i]) begin
            exp_state = q[i];
            exp_vec   = model(q[i], op, z);
            exp_valid = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        exp_valid = 1'b0;
        $display("instr op=%0d funct=%0d zero=%0d steps=%0d", op, fn, z, q.size());
    endtask

    task automatic latency(input string name, input int op, input int fn, input int req);
        int n;
        bus.opcode = 6'(op);
        bus.funct  = 6'(fn);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.state != 0 && n < 8);
        pin(name, n, req);
        $display("latency %s cycles=%0d", name, n);
    endtask

    initial begin
        bus.opcode  = 6'd35;
        bus.funct   = 6'd0;
        bus.aluZero = 1'b0;
`ifdef MULTI_MEM_WAIT_EN
        bus.memReady = 1'b1;
`endif
        step();
        step();
        pin("reset_outputs", int'(dut_out()), 0);
        pin("reset_state", int'(bus.state), 0);
        reset = 1'b0;
        #1;
        pin("fetch_after_reset", int'(bus.irWrite), 1);

        do_instr(35, 0, 1'b0);
        do_instr(43, 0, 1'b0);
        do_instr(0, 32, 1'b0);
        do_instr(0, 8, 1'b0);
        do_instr(4, 0, 1'b1);
        do_instr(4, 0, 1'b0);
        do_instr(5, 0, 1'b1);
        do_instr(5, 0, 1'b0);
        do_instr(2, 0, 1'b0);
        do_instr(3, 0, 1'b0);
        do_instr(8, 0, 1'b0);
        do_instr(13, 0, 1'b0);
        do_instr(63, 0, 1'b0);
        do_instr(35, 0, 1'b1);

        latency("lat_lw", 35, 0, 5);
        latency("lat_sw", 43, 0, 4);
        latency("lat_add", 0, 32, 4);
        latency("lat_ori", 13, 0, 4);
        latency("lat_jr", 0, 8, 3);
        latency("lat_jal", 3, 0, 3);
        latency("lat_illegal", 63, 0, 2);

        // lw walks 0,1,2,3,4 and only the last step loads MDR into the register file
        bus.opcode = 6'd35;
        step(); step(); step(); step();
        pin("lw_state4", int'(bus.state), 4);
        pin("lw_memToReg", int'(bus.memToReg), 1);
        pin("lw_regWrite", int'(bus.regWrite), 1);
        step();

        // bne with zero flag set must not load the PC
        bus.opcode = 6'd5;
        bus.aluZero = 1'b1;
        step(); step();
        pin("bne_state", int'(bus.state), 8);
        pin("bne_pcWrite", int'(bus.pcWrite), 0);
        pin("bne_pcSrc", int'(bus.pcSrc), 1);
        step();

        // jal writes $31 with the link value and jumps
        bus.opcode = 6'd3;
        step(); step();
        pin("jal_state", int'(bus.state), 13);
        pin("jal_regDst", int'(bus.regDst), 2);
        pin("jal_memToReg", int'(bus.memToReg), 2);
        pin("jal_pcWrite", int'(bus.pcWrite), 1);
        step();

        // illegal opcode: one pulse in DECODE, straight back to FETCH
        bus.opcode = 6'd63;
        step();
        pin("illegal_pulse", int'(bus.illegalOp), 1);
        step();
        pin("illegal_back", int'(bus.state), 0);
        pin("illegal_gone", int'(bus.illegalOp), 0);

`ifdef MULTI_MEM_WAIT_EN
        bus.opcode = 6'd2;
        bus.memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin("hold_state", int'(bus.state), 0);
            pin("hold_irWrite", int'(bus.irWrite), 0);
            pin("hold_memRead", int'(bus.memRead), 1);
            step();
        end
        bus.memReady = 1'b1;
        #1;
        pin("ready_irWrite", int'(bus.irWrite), 1);
        pin("ready_pcWrite", int'(bus.pcWrite), 1);
        step();
        pin("ready_decode", int'(bus.state), 1);
        step();
        step();
        $display("hold test done");
`endif

        // reset during MEM_WRITE suppresses the store and restarts at FETCH
        bus.opcode = 6'd43;
        step(); step(); step();
        pin("sw_state5", int'(bus.state), 5);
        pin("sw_memWrite", int'(bus.memWrite), 1);
        reset = 1'b1;
        #1;
        pin("rst_memWrite", int'(bus.memWrite), 0);
        step();
        reset = 1'b0;
        #1;
        pin("rst_restart_state", int'(bus.state), 0);
        pin("rst_restart_irWrite", int'(bus.irWrite), 1);
        step();
        pin("rst_restart_decode", int'(bus.state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
